exec_datapath: RTL
==================

Name: exec_datapath

Overview:
Execute-stage datapath directly downstream of the control unit. It consumes the one-cycle control strobes (we_a, we_b, do_alu, do_store, alu_op) and the current instruction byte. It holds registers A, B and the result register R with flags, and queues STORE operations into a small store queue. The queue drains to data memory over a valid/ready handshake, so memory back-pressure never stalls the control FSM.

Parameters:
DW, 8, data width of A/B/R and store data
AW, 4, store address width; address is instr[AW-1:0]
SQ_DEPTH, 4, store queue entries; power of 2, minimum 2

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous reset, active-high
instr  input  8  current instruction; instr[3:0] is the immediate and the store address
we_a  input  1  load A strobe
we_b  input  1  load B strobe
alu_op  input  2  00 ADD, 01 SUB, 10 AND, 11 OR
do_alu  input  1  execute ALU strobe
do_store  input  1  enqueue store strobe
st_valid  output  1  store queue head valid
st_ready  input  1  data memory accepts head
st_addr  output  AW  head store address
st_data  output  DW  head store data
reg_a_o  output  DW  register A
reg_b_o  output  DW  register B
result_o  output  DW  result register R
flag_z  output  1  zero flag
flag_c  output  1  carry/borrow flag
sq_count  output  clog2(SQ_DEPTH)+1  queue occupancy
st_overflow  output  1  sticky: a store was dropped on a full queue

Behaviour:
- Reset (async assert; release is synchronous to clk): A, B, R = 0; flag_z = 1; flag_c = 0; queue empty; st_valid = 0; st_addr = 0; st_data = 0; sq_count = 0; st_overflow = 0. Reset mid-drain discards all queued entries.
- Strobes are sampled on the rising edge. Each strobe acts independently, and any combination may be high in one cycle.
- we_a: A <= zero-extend(instr[3:0]) to DW. we_b does the same for B. Both strobes may be high together.
- do_alu: R and flags update one cycle after the strobe is sampled. Operands are the A and B values before this edge, so a same-cycle we_a/we_b does not affect this op.
  - ADD: {c,R} = A + B, using DW+1-bit arithmetic.
  - SUB: R = A − B mod 2^DW; c = 1 if A < B (borrow).
  - AND / OR: bitwise; c = 0.
  - flag_z = (R_new == 0).
- Flags and R hold when do_alu is low.
- do_store: enqueues {addr = instr[AW-1:0], data = R as it was before this edge}. With same-cycle do_alu, the store takes the old R.
- Queue: FIFO with the head presented on st_addr/st_data.
  - st_valid = queue not empty.
  - Pop occurs when st_valid && st_ready.
  - Head outputs stay stable while st_valid && !st_ready.
  - st_addr/st_data are don't-care when empty, and held at the last value.
- Full queue plus do_store:
  - Without a same-cycle pop, the entry is dropped, st_overflow <= 1 (sticky until rst), and sq_count is unchanged.
  - With a same-cycle pop, the push is accepted and the count is unchanged.
- Empty queue plus do_store: the entry appears on st_valid on the next cycle. There is no fall-through, giving a minimum latency of 1 cycle from strobe to st_valid.
- Push and pop in the same cycle when not empty/full: count unchanged; pointers wrap modulo SQ_DEPTH.
- sq_count is registered and reflects occupancy after the edge.

Decomposition:
- Shared package minicpu_pkg holds:
  - opcode constants OP_LOAD_A = 4'b0001, OP_LOAD_B = 4'b0010, OP_ADD = 4'b0100, OP_SUB = 4'b0101, OP_AND = 4'b0110, OP_OR = 4'b0111, OP_STORE = 4'b1000
  - ALU op constants ALU_ADD = 2'b00, ALU_SUB = 2'b01, ALU_AND = 2'b10, ALU_OR = 2'b11
  - DW/AW defaults
- One sub-module: store_queue, a parameterised synchronous FIFO with push, pop, full, empty and count outputs and an overflow flag. The ALU is inline combinational logic in exec_datapath.

Test Plan:
- rst pulse mid-operation with 3 entries queued -> all outputs at reset values immediately (async); flag_z = 1; st_valid = 0; sq_count = 0.
- we_a with instr = 0x15, we_b with instr = 0x23, then do_alu ADD -> A = 5, B = 3; next cycle R = 8, Z = 0, C = 0.
- do_alu SUB with A = 3, B = 5 -> R = 0xFE, C = 1, Z = 0. do_alu AND with A = 5, B = 2 -> R = 0, Z = 1, C = 0.
- R = 0x08, do_store with instr = 0x8A, st_ready = 1 -> next cycle st_valid = 1, st_addr = 0xA, st_data = 0x08; popped the same cycle; then sq_count = 0.
- st_ready = 0, 5 consecutive do_store with addresses 1..5 -> sq_count = 4; 5th dropped; st_overflow = 1. Raise st_ready -> drains addresses 1,2,3,4 in order; head stable while stalled.
- Full queue with st_ready = 1 and do_store in the same cycle -> push accepted, sq_count stays 4, st_overflow stays 0. Same-cycle do_alu + do_store -> queued data equals the pre-update R.

Source files
------------

// File: rtl/minicpu_pkg.sv
// Shared constants for the mini CPU: opcodes, ALU operation codes and default widths.
package minicpu_pkg;

  localparam int DW_DEF = 8;
  localparam int AW_DEF = 4;

  localparam logic [3:0] OP_LOAD_A = 4'b0001;
  localparam logic [3:0] OP_LOAD_B = 4'b0010;
  localparam logic [3:0] OP_ADD    = 4'b0100;
  localparam logic [3:0] OP_SUB    = 4'b0101;
  localparam logic [3:0] OP_AND    = 4'b0110;
  localparam logic [3:0] OP_OR     = 4'b0111;
  localparam logic [3:0] OP_STORE  = 4'b1000;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_OR  = 2'b11;

endpackage

// File: rtl/exec_datapath_store_queue.sv
// Synchronous FIFO holding pending stores; the head is presented combinationally and
// is held at the last popped value while the queue is empty.
module store_queue #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count,
  output logic             overflow
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [WIDTH-1:0] last_head;
  logic             pop_ok;
  logic             push_ok;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  // A full queue still accepts a push when the head leaves in the same cycle.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  assign head_data = empty ? last_head : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      last_head <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok) begin
        rd_ptr    <= rd_ptr + PW'(1);
        last_head <= mem[rd_ptr];
      end
      if (push && !push_ok) overflow <= 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/exec_datapath.sv
// Execute stage: A/B operand registers, inline ALU with result/flags, and a store queue
// that decouples data-memory back-pressure from the control unit.
module exec_datapath
  import minicpu_pkg::*;
#(
  parameter int DW       = DW_DEF,
  parameter int AW       = AW_DEF,
  parameter int SQ_DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [7:0]                instr,
  input  logic                      we_a,
  input  logic                      we_b,
  input  logic [1:0]                alu_op,
  input  logic                      do_alu,
  input  logic                      do_store,
  output logic                      st_valid,
  input  logic                      st_ready,
  output logic [AW-1:0]             st_addr,
  output logic [DW-1:0]             st_data,
  output logic [DW-1:0]             reg_a_o,
  output logic [DW-1:0]             reg_b_o,
  output logic [DW-1:0]             result_o,
  output logic                      flag_z,
  output logic                      flag_c,
  output logic [$clog2(SQ_DEPTH):0] sq_count,
  output logic                      st_overflow
);

  localparam int CW = $clog2(SQ_DEPTH) + 1;

  logic [DW-1:0] reg_a;
  logic [DW-1:0] reg_b;
  logic [DW-1:0] reg_r;
  logic [DW-1:0] imm_ext;
  logic [DW:0]   alu_wide;
  logic [DW-1:0] alu_r;
  logic          alu_c;
  logic          sq_full;
  logic          sq_empty;
  logic [CW-1:0] sq_cnt;
  logic          unused_instr;

  assign imm_ext      = {{(DW-4){1'b0}}, instr[3:0]};
  assign unused_instr = ^instr;

  always_comb begin
    alu_wide = '0;
    alu_r    = '0;
    alu_c    = 1'b0;
    case (alu_op)
      ALU_ADD: begin
        alu_wide = {1'b0, reg_a} + {1'b0, reg_b};
        alu_r    = alu_wide[DW-1:0];
        alu_c    = alu_wide[DW];
      end
      ALU_SUB: begin
        // The extra bit of a zero-extended subtraction is the borrow (A < B).
        alu_wide = {1'b0, reg_a} - {1'b0, reg_b};
        alu_r    = alu_wide[DW-1:0];
        alu_c    = alu_wide[DW];
      end
      ALU_AND: alu_r = reg_a & reg_b;
      default: alu_r = reg_a | reg_b;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_a  <= '0;
      reg_b  <= '0;
      reg_r  <= '0;
      flag_z <= 1'b1;
      flag_c <= 1'b0;
    end else begin
      if (we_a) reg_a <= imm_ext;
      if (we_b) reg_b <= imm_ext;
      if (do_alu) begin
        reg_r  <= alu_r;
        flag_z <= (alu_r == '0);
        flag_c <= alu_c;
      end
    end
  end

  // Handshake: st_valid rises only when an entry is queued and is never withdrawn
  // until taken; st_addr/st_data are stable while st_valid && !st_ready, and the head
  // is consumed on exactly the rising edge where st_valid && st_ready.
  store_queue #(
    .WIDTH (AW + DW),
    .DEPTH (SQ_DEPTH)
  ) u_store_queue (
    .clk       (clk),
    .rst       (rst),
    .push      (do_store),
    .push_data ({instr[AW-1:0], reg_r}),
    .pop       (st_ready),
    .head_data ({st_addr, st_data}),
    .full      (sq_full),
    .empty     (sq_empty),
    .count     (sq_cnt),
    .overflow  (st_overflow)
  );

  assign st_valid = !sq_empty;
  assign sq_count = sq_cnt;
  assign reg_a_o  = reg_a;
  assign reg_b_o  = reg_b;
  assign result_o = reg_r;

endmodule
